glb_dma_hdr_queue: RTL

GLB_DMA_HDR_QUEUE -- requirements
Module: glb_dma_hdr_queue

---
 rtl/glb_dma_hdr_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/glb_dma_hdr_queue.sv
// Per-channel DMA header queue: software fills/validates entries, consumer drains in order.
// Optional lock-violation counter and err_irq port under GLB_HDR_QUEUE_ERR_EN.
module glb_dma_hdr_queue #(
    parameter int NUM_CH         = 2,
    parameter int QUEUE_DEPTH    = 4,
    parameter int ADDR_WIDTH     = 22,
    parameter int WORDS_WIDTH    = 21,
    parameter int CFG_DATA_WIDTH = 32,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int Q_W           = $clog2(QUEUE_DEPTH),
    localparam int CFG_ADDR_W    = CH_W + Q_W + 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cfg_wr_en,
    input  logic                                  cfg_rd_en,
    input  logic [CFG_ADDR_W-1:0]                 cfg_addr,
    input  logic [CFG_DATA_WIDTH-1:0]             cfg_wr_data,
    output logic [CFG_DATA_WIDTH-1:0]             cfg_rd_data,
    output logic                                  cfg_rd_valid,
    output logic [NUM_CH-1:0]                     hdr_valid,
    input  logic [NUM_CH-1:0]                     hdr_ready,
    output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     hdr_start_addr,
    output logic [NUM_CH-1:0][WORDS_WIDTH-1:0]    hdr_num_words
`ifdef GLB_HDR_QUEUE_ERR_EN
    ,
    output logic                                  err_irq
`endif
);

    logic [CH_W-1:0]             a_ch;
    logic [Q_W-1:0]              a_ent;
    logic [1:0]                  a_fld;
    logic                        a_ok;
    logic                        wr_ok;
    logic                        locked;
    logic                        drop;
    logic [QUEUE_DEPTH-1:0]      valid_q [NUM_CH];
    logic [ADDR_WIDTH-1:0]       addr_q  [NUM_CH][QUEUE_DEPTH];
    logic [WORDS_WIDTH-1:0]      words_q [NUM_CH][QUEUE_DEPTH];
    logic [Q_W-1:0]              head_q  [NUM_CH];
    logic [Q_W:0]                count   [NUM_CH];
    logic [NUM_CH-1:0]           pop;
    logic [CFG_DATA_WIDTH-1:0]   rd_val;
    logic                        unused_wdata;

    assign {a_ch, a_ent, a_fld} = cfg_addr;
    assign a_ok   = int'(a_ch) < NUM_CH;
    assign wr_ok  = cfg_wr_en && a_ok;
    assign locked = a_ok && valid_q[a_ch][a_ent];
    assign drop   = wr_ok && locked && (a_fld == 2'd1 || a_fld == 2'd2);
    assign unused_wdata = ^cfg_wr_data;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            hdr_valid[c]      = valid_q[c][head_q[c]];
            hdr_start_addr[c] = addr_q[c][head_q[c]];
            hdr_num_words[c]  = words_q[c][head_q[c]];
            pop[c]            = hdr_valid[c] && hdr_ready[c];
            count[c]          = '0;
            for (int e = 0; e < QUEUE_DEPTH; e++)
                count[c] = count[c] + (Q_W+1)'(valid_q[c][e]);
        end
    end

`ifdef GLB_HDR_QUEUE_ERR_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
            err_irq <= 1'b0;
        end else begin
            err_irq <= (err_cnt != 8'd0);
            if (wr_ok && a_fld == 2'd3 && a_ch == '0)
                err_cnt <= '0;
            else if (drop && err_cnt != 8'hff)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

    // Reads see pre-write register state.
    always_comb begin
        rd_val = '0;
        if (a_ok) begin
            unique case (a_fld)
                2'd0: rd_val[0] = valid_q[a_ch][a_ent];
                2'd1: rd_val[ADDR_WIDTH-1:0] = addr_q[a_ch][a_ent];
                2'd2: rd_val[WORDS_WIDTH-1:0] = words_q[a_ch][a_ent];
                2'd3: begin
                    rd_val[Q_W:0]         = count[a_ch];
                    rd_val[2*Q_W:Q_W+1]   = head_q[a_ch];
`ifdef GLB_HDR_QUEUE_ERR_EN
                    rd_val[31:24]         = err_cnt;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_rd_data  <= '0;
            cfg_rd_valid <= 1'b0;
        end else begin
            cfg_rd_data  <= cfg_rd_en ? rd_val : '0;
            cfg_rd_valid <= cfg_rd_en;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                valid_q[c] <= '0;
                head_q[c]  <= '0;
                for (int e = 0; e < QUEUE_DEPTH; e++) begin
                    addr_q[c][e]  <= '0;
                    words_q[c][e] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (pop[c]) begin
                    valid_q[c][head_q[c]] <= 1'b0;
                    head_q[c]             <= head_q[c] + Q_W'(1);
                end
            end
            if (wr_ok && !locked && a_fld == 2'd1)
                addr_q[a_ch][a_ent] <= cfg_wr_data[ADDR_WIDTH-1:0];
            if (wr_ok && !locked && a_fld == 2'd2)
                words_q[a_ch][a_ent] <= cfg_wr_data[WORDS_WIDTH-1:0];
            // A consume of the same entry overrides a validate write.
            if (wr_ok && a_fld == 2'd0 &&
                !(pop[a_ch] && head_q[a_ch] == a_ent))
                valid_q[a_ch][a_ent] <= cfg_wr_data[0];
        end
    end

endmodule
